// File: rtl/act_pkg.sv
// Shared types and constants for the activation unit: per-sample mode codes,
// the 1/6 reciprocal used by the hard-sigmoid scaling and a saturation helper.
package act_pkg;

    typedef enum logic [2:0] {
        BYPASS   = 3'd0,
        RELU     = 3'd1,
        RELU6    = 3'd2,
        HSIGMOID = 3'd3,
        HSWISH   = 3'd4
    } act_mode_e;

    // round(2^16 / 6); the scaled product is shifted back down by RECIP_SHIFT.
    localparam int RECIP6      = 10923;
    localparam int RECIP_SHIFT = 16;

    // Clamp a signed value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Unassigned codes 5-7 fall back to a plain pass-through.
    function automatic act_mode_e decode_mode(input logic [2:0] code);
        act_mode_e m;
        case (code)
            3'd1:    m = RELU;
            3'd2:    m = RELU6;
            3'd3:    m = HSIGMOID;
            3'd4:    m = HSWISH;
            default: m = BYPASS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/act_hsig_core.sv
// Three-register arithmetic datapath: clip(x+3) in S1, x*c or c in S2,
// 1/6 scaling or ReLU/ReLU6/bypass selection plus saturation in S3.
module act_hsig_core
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld1,
    input  logic                  ld2,
    input  logic                  ld3,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  act_mode_e             mode_s1,
    input  act_mode_e             mode_s2,
    output logic [DATA_WIDTH-1:0] y_out
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;
    // Scaling width must stay within the 64-bit saturation helper (DATA_WIDTH <= 23).
    localparam int SW = PW + RECIP_SHIFT + 2;

    localparam logic signed [DW:0]   THREE_E  = (DW + 1)'(3 << FRAC_BITS);
    localparam logic signed [DW:0]   SIX_E    = (DW + 1)'(6 << FRAC_BITS);
    localparam logic signed [SW-1:0] SIX_S    = SW'(6 << FRAC_BITS);
    localparam logic signed [SW-1:0] RECIP_S  = SW'(RECIP6);

    logic signed [DW-1:0] x1_q, x1_d;
    logic signed [DW-1:0] c1_q, c1_d;
    logic signed [PW-1:0] p2_q, p2_d;
    logic signed [DW-1:0] y3_q, y3_d;

    logic signed [DW:0]   sum1;
    logic signed [PW-1:0] x_w;
    logic signed [PW-1:0] c_w;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] p_s;
    logic signed [SW-1:0] scaled;
    logic signed [SW-1:0] y_pre;
    logic signed [63:0]   y_sat;

    always_comb begin
        x1_d = x1_q;
        c1_d = c1_q;
        sum1 = $signed({in_data[DW-1], in_data}) + THREE_E;
        if (ld1) begin
            x1_d = $signed(in_data);
            if (sum1[DW]) begin
                c1_d = '0;
            end else if (sum1 > SIX_E) begin
                c1_d = SIX_E[DW-1:0];
            end else begin
                c1_d = sum1[DW-1:0];
            end
        end
    end

    always_comb begin
        p2_d = p2_q;
        x_w  = PW'(x1_q);
        c_w  = PW'(c1_q);
        prod = x_w * c_w;
        if (ld2) begin
            case (mode_s1)
                HSWISH:   p2_d = prod >>> FRAC_BITS;
                HSIGMOID: p2_d = c_w;
                default:  p2_d = x_w;
            endcase
        end
    end

    always_comb begin
        y3_d   = y3_q;
        p_s    = SW'(p2_q);
        scaled = (p_s * RECIP_S) >>> RECIP_SHIFT;
        case (mode_s2)
            HSWISH, HSIGMOID: y_pre = scaled;
            RELU:             y_pre = p_s[SW-1] ? '0 : p_s;
            RELU6: begin
                if (p_s[SW-1]) begin
                    y_pre = '0;
                end else if (p_s > SIX_S) begin
                    y_pre = SIX_S;
                end else begin
                    y_pre = p_s;
                end
            end
            default:          y_pre = p_s;
        endcase
        y_sat = sat_to_width(64'(y_pre), DW);
        if (ld3) begin
            y3_d = y_sat[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            c1_q <= '0;
            p2_q <= '0;
            y3_q <= '0;
        end else begin
            x1_q <= x1_d;
            c1_q <= c1_d;
            p2_q <= p2_d;
            y3_q <= y3_d;
        end
    end

    assign y_out = y3_q;

endmodule

// File: rtl/activation_unit_param.sv
// Pipelined multi-mode activation unit: owns the stage valids, global stall,
// per-sample mode pipe and output channel counter around act_hsig_core.
module activation_unit_param
    import act_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2:0]                      cfg_mode,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(NUM_CHANNELS)-1:0] out_ch,
    output logic                            out_last
);

    localparam int CH_W = $clog2(NUM_CHANNELS);

    // Handshake: a beat moves when valid && ready on the same edge; a held
    // output (valid && !ready) freezes every stage, so in_ready is simply !stall.
    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic            v3_q, v3_d;
    act_mode_e       mode1_q, mode1_d;
    act_mode_e       mode2_q, mode2_d;
    logic [CH_W-1:0] ch_q, ch_d;

    logic stall;
    logic adv;
    logic ld1;
    logic ld2;
    logic ld3;

    assign stall    = v3_q && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;
    assign ld1      = adv && in_valid;
    assign ld2      = adv && v1_q;
    assign ld3      = adv && v2_q;

    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        mode1_d = mode1_q;
        mode2_d = mode2_q;
        ch_d    = ch_q;
        if (adv) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            if (in_valid) begin
                mode1_d = decode_mode(cfg_mode);
            end
            if (v1_q) begin
                mode2_d = mode1_q;
            end
        end
        if (v3_q && out_ready) begin
            ch_d = (ch_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= BYPASS;
            mode2_q <= BYPASS;
            ch_q    <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            mode1_q <= mode1_d;
            mode2_q <= mode2_d;
            ch_q    <= ch_d;
        end
    end

    act_hsig_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .ld1    (ld1),
        .ld2    (ld2),
        .ld3    (ld3),
        .in_data(in_data),
        .mode_s1(mode1_q),
        .mode_s2(mode2_q),
        .y_out  (out_data)
    );

    assign out_valid = v3_q;
    assign out_ch    = ch_q;
    assign out_last  = (ch_q == CH_W'(NUM_CHANNELS - 1));

endmodule

// File: tb/tb_activation_unit_param.sv
// Scoreboard bench for activation_unit_param: driver pushes model results,
// a negedge monitor pops and compares data, channel, last flag and latency.
module tb_activation_unit_param;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NC = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cfg_mode;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic          out_last;

  activation_unit_param #(
    .DATA_WIDTH  (DW),
    .FRAC_BITS   (FB),
    .NUM_CHANNELS(NC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_last (out_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  bit            lat_on = 0;
  int            last_hits = 0;
  int            exp_ch = 0;
  int            out_count = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: activation rules in plain integer arithmetic.
  function automatic logic [DW-1:0] ref_model(input int mode, input int x);
    longint c, p, y;
    longint three, six;
    three = 3 * (1 << FB);
    six   = 6 * (1 << FB);
    c = longint'(x) + three;
    if (c < 0) c = 0;
    if (c > six) c = six;
    case (mode & 7)
      1: y = (x < 0) ? 0 : x;
      2: y = (x < 0) ? 0 : ((x > six) ? six : x);
      3: y = (c * 10923) >>> 16;
      4: begin
        p = (longint'(x) * c) >>> FB;
        y = (p * 10923) >>> 16;
      end
      default: y = x;
    endcase
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return DW'(y);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int m, input int d);
    int  waited = 0;
    bit  done = 0;
    cfg_mode = 3'(m);
    in_data  = DW'(d);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_q.push_back(ref_model(m, d));
        acc_q.push_back(cycle);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 100) begin
          chk("send_timeout", 1, 0);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    cfg_mode = 3'($urandom_range(0, 7));
    in_data  = DW'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int waited = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_left", exp_q.size(), 0);
    idle(2);
  endtask

  function automatic int rand_data();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 4096)) - 2048;
  endfunction

  // ---------------- monitor ----------------
  logic [DW-1:0] mon_exp;
  int            mon_acc;
  bit            rst_seen = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [CW-1:0] prev_ch;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      exp_ch     = 0;
      rst_seen   = 1;
      prev_stall = 0;
    end else begin
      if (rst_seen) begin
        chk("out_valid_after_rst", out_valid, 0);
        rst_seen = 0;
      end
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", out_data, prev_data);
        chk("stall_ch_held", out_ch, prev_ch);
        chk("stall_last_held", out_last, prev_last);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", out_data, -1);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_acc = acc_q.pop_front();
          chk("out_data", longint'($signed(out_data)), longint'($signed(mon_exp)));
          chk("out_ch", out_ch, exp_ch);
          chk("out_last", out_last, (exp_ch == NC - 1) ? 1 : 0);
          if (lat_on) chk("latency", cycle - mon_acc, 3);
        end
        if (out_last) last_hits++;
        out_count++;
        exp_ch = (exp_ch + 1) % NC;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ch    = out_ch;
      prev_last  = out_last;
    end
  end

  // ---------------- stimulus ----------------
  int dir_m[22] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 4,
                    0, 0, 4, 4, 5, 7, 2, 3};
  int dir_d[22] = '{-1280, 0, 1792, -512, 1792, 640, -256, 0, -1024, 1024,
                    256, -256, -768, 1280, -32768, 32767, 32767, -32768,
                    1234, -999, 32767, 32767};
  int mix_m[4]  = '{1, 4, 3, 0};
  bit rand_done;
  int hits_before;
  int count_before;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    cfg_mode  = 3'd0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed values and boundaries, free-flowing output, latency checked.
    lat_on = 1;
    for (int i = 0; i < 22; i++) send(dir_m[i], dir_d[i]);
    drain();
    lat_on = 0;

    // Reset with two samples in flight, then mixed modes from channel 0.
    send(1, 100);
    send(4, 256);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    chk("no_output_after_rst", out_count, 0 + out_count_snapshot());
    lat_on = 1;
    for (int i = 0; i < 4; i++) send(mix_m[i], rand_data());
    drain();
    lat_on = 0;

    // Backpressure: 20 HSWISH samples with a 5-cycle output stall mid-stream.
    hits_before  = last_hits;
    count_before = out_count;
    fork
      begin
        for (int i = 0; i < 20; i++) send(4, rand_data());
        in_valid = 1'b0;
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_output_count", out_count - count_before, 20);
    chk("bp_last_seen", (last_hits > hits_before) ? 1 : 0, 1);

    // Randomized modes, data, input gaps and output backpressure.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(int'($urandom_range(0, 7)), rand_data());
        end
        in_valid  = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Output count captured when the mid-operation reset was released.
  int rst_count_snap = 0;
  always @(negedge rst) rst_count_snap = out_count;
  function automatic int out_count_snapshot();
    return rst_count_snap;
  endfunction

endmodule
